mdu_param: RTL and testbench

MDU_PARAM -- requirements
Module: mdu_param

---
 rtl/mdu_param.sv | 152 +++++++++++++++
 tb/tb_mdu_param.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mdu_param.sv
// Multiply/divide unit with HI/LO registers: fixed-latency MULT/DIV/MADD/MSUB
// with flush, direct HI/LO writes and a one-cycle done pulse on commit.
module mdu_param #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [1:0]       we,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CMAX  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W = $clog2(CMAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       op_q, op_nxt;
    logic [WIDTH-1:0] a_q, a_nxt, b_q, b_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic             done_nxt, busy_nxt;

    // Multiply datapath: operands extended to 2*WIDTH so one multiplier serves both signednesses
    logic          mul_sgn;
    logic [W2-1:0] a_ext, b_ext, prod, acc, mul_res;

    always_comb begin
        mul_sgn = ~op_q[0];
        a_ext   = mul_sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext   = mul_sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod    = a_ext * b_ext;
        acc     = {hi, lo};
        if (!op_q[2])
            mul_res = prod;
        else if (op_q[1])
            mul_res = acc - prod;
        else
            mul_res = acc + prod;
    end

    // Divide datapath: sign-magnitude, so MIN / -1 falls out as MIN with zero remainder
    logic             div_sgn, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    always_comb begin
        div_sgn = ~op_q[0];
        a_neg   = div_sgn & a_q[WIDTH-1];
        b_neg   = div_sgn & b_q[WIDTH-1];
        a_mag   = a_neg ? WIDTH'(-a_q) : a_q;
        b_mag   = b_neg ? WIDTH'(-b_q) : b_q;
        b_zero  = (b_q == '0);
        q_mag   = b_zero ? '0 : a_mag / b_mag;
        r_mag   = b_zero ? '0 : a_mag % b_mag;
        quo     = (a_neg ^ b_neg) ? WIDTH'(-q_mag) : q_mag;
        rem     = a_neg ? WIDTH'(-r_mag) : r_mag;
    end

    // Next-state and HI/LO update
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        hi_nxt    = hi;
        lo_nxt    = lo;
        done_nxt  = 1'b0;

        if (flush) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_nxt = op;
                        a_nxt  = d1;
                        b_nxt  = d2;
                        if (op[2:1] == 2'b01) begin
                            state_nxt = S_DIV;
                            cnt_nxt   = CNT_W'(DIV_CYCLES);
                        end else begin
                            state_nxt = S_MUL;
                            cnt_nxt   = CNT_W'(MULT_CYCLES);
                        end
                    end else if (we == 2'b01) begin
                        hi_nxt = d1;
                    end else if (we == 2'b10) begin
                        lo_nxt = d1;
                    end
                end
                S_MUL, S_DIV: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                        if (state == S_MUL) begin
                            {hi_nxt, lo_nxt} = mul_res;
                        end else if (!b_zero) begin
                            hi_nxt = rem;
                            lo_nxt = quo;
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mdu_param.sv
// Scoreboard bench for mdu_param: directed ops push expected {hi,lo};
// a negedge monitor pops and compares on every done pulse.
module tb_mdu_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] d1, d2;
    logic [1:0]  we;
    logic        flush;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    mdu_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
        .we(we), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {hi, lo}, 64'hx);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("result_hilo", {hi, lo}, e);
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int n,
                          input bit poke, input logic [1:0] w);
        int cnt;
        start = 1'b1; op = o; d1 = a; d2 = b; we = w;
        exp_q.push_back({eh, el});
        @(posedge clk); #1;
        start = 1'b0; we = 2'b00; cnt = 0;
        if (poke) begin
            start = 1'b1; op = 3'd2; d1 = 32'd99; d2 = 32'd0;
        end
        while (busy === 1'b1 && cnt < 500) begin
            cnt++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("busy_len", 64'(cnt), 64'(n));
    endtask

    task automatic load(input logic [31:0] h, input logic [31:0] l);
        we = 2'b01; d1 = h;
        @(posedge clk); #1;
        we = 2'b10; d1 = l;
        @(posedge clk); #1;
        we = 2'b00;
        chk("load_hilo", {hi, lo}, {h, l});
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; d1 = '0; d2 = '0; we = 2'b00; flush = 1'b0;
        #3;
        chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // MULT -2*3, issued right after reset release
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1'b0, 2'b00);
        chk("done_after_mult", 64'(done), 64'd1);
        // Back-to-back DIV / DIVU starting in the done cycle
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0, 2'b00);
        run_op(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0, 2'b00);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);

        load(32'd0, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd1, 32'd1, 32'd1, 32'd0, 5, 1'b0, 2'b00);
        load(32'd0, 32'd0);
        run_op(3'd6, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, 2'b00);

        // Divide by zero leaves HI/LO alone but still completes
        load(32'h11, 32'h22);
        run_op(3'd2, 32'd123, 32'd0, 32'h11, 32'h22, 10, 1'b0, 2'b00);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0, 2'b00);

        // Flush in the third busy cycle of a MULT
        start = 1'b1; op = 3'd0; d1 = 32'd5; d2 = 32'd5;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (8) @(posedge clk);
        #1 chk("flush_hilo", {hi, lo}, {32'd0, 32'h8000_0000});

        // start with we=01 together: MADDU runs, HI not written; a start while busy is dropped
        run_op(3'd5, 32'd2, 32'd3, 32'd0, 32'h8000_0006, 5, 1'b1, 2'b01);
        @(posedge clk); #1;
        chk("ignored_start", 64'(busy), 64'd0);

        // Reset in the fourth cycle of a DIV
        start = 1'b1; op = 3'd2; d1 = 32'd100; d2 = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1 chk("async_reset", {30'd0, busy, done, hi, lo}, 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1'b0, 2'b00);

        repeat (3) @(posedge clk);
        #1 chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
